// File: rtl/sequential_mul_if.sv
// sequential_mul_if: request/result bundle for the shift-add multiplier.
//   master : drives flag, multiplicand, multiplier; observes the results
//   slave  : the multiplier itself
//   flag          start request, level-sampled on each rising clk
//   multiplicand  operand A (A_W bits), captured on the accepting edge
//   multiplier    operand B (B_W bits), captured on the accepting edge
//   product       registered A*B (A_W+B_W bits)
//   scaled        registered product >> B_W (A_W bits)
//   busy          operation in flight (LOAD or MULT)
//   done          result valid, ready for a new request
interface sequential_mul_if #(
    parameter int A_W = 16,
    parameter int B_W = 8
);
    logic                 flag;
    logic [A_W-1:0]       multiplicand;
    logic [B_W-1:0]       multiplier;
    logic [A_W+B_W-1:0]   product;
    logic [A_W-1:0]       scaled;
    logic                 busy;
    logic                 done;

    modport master (
        output flag, multiplicand, multiplier,
        input  product, scaled, busy, done
    );

    modport slave (
        input  flag, multiplicand, multiplier,
        output product, scaled, busy, done
    );
endinterface

// File: rtl/sequential_mul.sv
// sequential_mul: multi-cycle shift-add multiplier, one multiplier bit per
// clock, MSB first. Rebuilds a count-domain value from a fixed-point
// quotient and its divisor: scaled = (multiplicand * multiplier) >> B_W.
//
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    sequential_mul_if.slave (flag, operands in; product, scaled,
//          busy, done out)
//
// Build option:
//   SEQ_MUL_ROUND_EN  defined -> scaled is round-half-up with saturation;
//                     undefined -> scaled is the truncated upper A_W bits.
//                     product is the same in both builds.
module sequential_mul #(
    parameter int A_W = 16,
    parameter int B_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    sequential_mul_if.slave  bus
);
    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_MULT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    logic [P_W-1:0]   acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [P_W-1:0]   prod_q;
    logic [A_W-1:0]   scaled_q;

    logic [P_W-1:0]   next_acc;
    logic [A_W-1:0]   scaled_next;

    // MSB-first shift-add: after B_W steps acc holds A*B exactly.
    always_comb begin
        next_acc = {acc_q[P_W-2:0], 1'b0};
        if (b_q[B_W-1])
            next_acc = next_acc + P_W'(a_q);
    end

`ifdef SEQ_MUL_ROUND_EN
    // (p + 2^(B_W-1)) >> B_W equals upper(p) + p[B_W-1]; the extra top bit
    // catches a carry out of A_W bits, which saturates.
    logic [A_W:0] rnd_q;
    always_comb begin
        rnd_q       = {1'b0, next_acc[P_W-1:B_W]} + {{A_W{1'b0}}, next_acc[B_W-1]};
        scaled_next = rnd_q[A_W] ? {A_W{1'b1}} : rnd_q[A_W-1:0];
    end
`else
    always_comb begin
        scaled_next = next_acc[P_W-1:B_W];
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            scaled_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new request directly (back-to-back).
                    if (bus.flag) begin
                        a_q   <= bus.multiplicand;
                        b_q   <= bus.multiplier;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    state <= S_MULT;
                end
                S_MULT: begin
                    acc_q <= next_acc;
                    b_q   <= {b_q[B_W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        prod_q   <= next_acc;
                        scaled_q <= scaled_next;
                        state    <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.product = prod_q;
    assign bus.scaled  = scaled_q;
    assign bus.busy    = (state == S_LOAD) || (state == S_MULT);
    assign bus.done    = (state == S_DONE);
endmodule

// File: tb/tb_sequential_mul.sv
// tb_sequential_mul: drives the multiplier through directed and random
// operations and compares against plain-arithmetic expectations.
module tb_sequential_mul;
    localparam int A_W = 16;
    localparam int B_W = 8;
    localparam int P_W = A_W + B_W;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sequential_mul_if #(.A_W(A_W), .B_W(B_W)) bus ();

    sequential_mul #(.A_W(A_W), .B_W(B_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [P_W-1:0] exp_prod;
    logic [A_W-1:0] exp_scaled;

    function automatic logic [P_W-1:0] model_prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return P_W'(p);
    endfunction

    function automatic logic [A_W-1:0] model_scaled(input logic [P_W-1:0] p);
        longint unsigned r;
`ifdef SEQ_MUL_ROUND_EN
        r = (longint'(p) + 128) / 256;
`else
        r = longint'(p) / 256;
`endif
        return (r > 65535) ? 16'hFFFF : 16'(r);
    endfunction

    task automatic check_idle(input string name, input logic want_done);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== want_done || bus.product !== exp_prod || bus.scaled !== exp_scaled) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b product=%h scaled=%h, want busy=0 done=%b product=%h scaled=%h",
                     name, bus.busy, bus.done, bus.product, bus.scaled, want_done, exp_prod, exp_scaled);
        end
    endtask

    // One full operation: accept, 9 busy cycles, then a done check.
    task automatic run_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input bit disturb);
        @(negedge clk);
        bus.flag = 1'b1; bus.multiplicand = a; bus.multiplier = b;
        @(posedge clk); #1;
        bus.flag = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.product !== exp_prod || bus.scaled !== exp_scaled) begin
                n_fail++;
                $display("FAIL busy_phase a=%h b=%h cyc=%0d: busy=%b done=%b product=%h scaled=%h, want busy=1 done=0 product=%h scaled=%h",
                         a, b, i, bus.busy, bus.done, bus.product, bus.scaled, exp_prod, exp_scaled);
            end
            if (disturb) begin
                bus.flag         = (i < 8) ? 1'($urandom) : 1'b0;
                bus.multiplicand = 16'($urandom);
                bus.multiplier   = 8'($urandom);
            end
        end
        exp_prod   = model_prod(a, b);
        exp_scaled = model_scaled(exp_prod);
        @(negedge clk);
        check_idle($sformatf("result a=%h b=%h", a, b), 1'b1);
    endtask

    task automatic test_reset();
        bus.flag = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        exp_prod = '0; exp_scaled = '0;
        n_rst = 1'b1;
        #3 n_rst = 1'b0;
        #9;
        check_idle("in_reset", 1'b0);
        @(negedge clk); n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("reset_idle", 1'b0);
        end
    endtask

    task automatic test_basic();
        run_op(16'd200, 8'h80, 1'b0);
        n_tests++;
        if (bus.product !== 24'h006400 || bus.scaled !== 16'h0064) begin
            n_fail++;
            $display("FAIL basic_const: product=%h scaled=%h, want 006400 0064", bus.product, bus.scaled);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("done_hold", 1'b1);
        end
    endtask

    task automatic test_max();
        run_op(16'hFFFF, 8'hFF, 1'b0);
        n_tests++;
        if (bus.product !== 24'hFEFF01 || bus.scaled !== 16'hFEFF) begin
            n_fail++;
            $display("FAIL max_const: product=%h scaled=%h, want FEFF01 FEFF", bus.product, bus.scaled);
        end
    endtask

    task automatic test_round();
        logic [A_W-1:0] want;
`ifdef SEQ_MUL_ROUND_EN
        want = 16'h0002;
`else
        want = 16'h0001;
`endif
        run_op(16'd3, 8'h80, 1'b0);
        n_tests++;
        if (bus.product !== 24'h000180 || bus.scaled !== want) begin
            n_fail++;
            $display("FAIL round_half: product=%h scaled=%h, want 000180 %h", bus.product, bus.scaled, want);
        end
    endtask

    task automatic test_ignore_flag();
        run_op(16'd10, 8'd10, 1'b1);
        n_tests++;
        if (bus.product !== 24'h000064) begin
            n_fail++;
            $display("FAIL ignore_flag: product=%h, want 000064", bus.product);
        end
    endtask

    task automatic test_back_to_back();
        run_op(16'd0, 8'h55, 1'b0);
        n_tests++;
        if (bus.product !== 24'h000000) begin
            n_fail++;
            $display("FAIL zero_operand: product=%h, want 000000", bus.product);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            run_op(16'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic test_reset_mid();
        run_op(16'd1234, 8'h77, 1'b0);
        @(negedge clk);
        bus.flag = 1'b1; bus.multiplicand = 16'd1000; bus.multiplier = 8'd5;
        @(posedge clk); #1;
        bus.flag = 1'b0;
        // i=0 is LOAD, i=1..4 are the first four MULT cycles
        for (int i = 0; i < 5; i++) @(negedge clk);
        n_rst = 1'b0;
        exp_prod = '0; exp_scaled = '0;
        #1;
        check_idle("reset_mid_async", 1'b0);
        @(negedge clk); n_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("post_reset_idle", 1'b0);
        end
        run_op(16'd1000, 8'd5, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_round();
        test_ignore_flag();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sequential_mul.md
Name: sequential_mul

Overview:
- Multi-cycle shift-add multiplier; the inverse of the team's sequential divider.
- Rebuilds a 16-bit count-domain value from an 8-bit fixed-point quotient and the 16-bit divisor used to produce it: scaled = (quotient × divisor) >> 8.
- Used in the synth datapath to turn note/ratio codes back into counter periods without a combinational multiplier array.
- One result per request; one operand bit per clock.

Parameters:
- A_W, 16, width of multiplicand (divisor operand).
- B_W, 8, width of multiplier (quotient operand); also the number of iterations and the fixed-point shift.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- flag  input  1  start request, level-sampled each rising edge.
- multiplicand  input  A_W  operand A, captured on the edge that accepts flag.
- multiplier  input  B_W  operand B, captured on the edge that accepts flag.
- product  output  A_W+B_W  full product A×B, registered.
- scaled  output  A_W  product >> B_W (rounded if feature enabled), registered.
- busy  output  1  high in LOAD and MULT.
- done  output  1  high in DONE (result valid, idle-ready).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, n_rst. No other reset.
- Reset: state=IDLE; iteration counter, operand regs, accumulator = 0; product=0, scaled=0, busy=0, done=0.
- States: IDLE, LOAD, MULT, DONE.
  - IDLE: flag=1 → LOAD, capturing multiplicand/multiplier into A/B regs on that edge.
  - LOAD: one cycle. Clears accumulator and iteration counter → MULT.
  - MULT: B_W cycles. Each edge: acc ← (acc<<1) + (B[B_W-1] ? A : 0); B ← B<<1; counter+1. On the edge where counter==B_W-1, → DONE.
  - MULT → DONE edge: product ← final next_acc; scaled ← its upper A_W bits (per feature).
  - DONE: holds. flag=1 → LOAD, capturing new operands (back-to-back restart).
- Latency: flag sampled at edge k → LOAD after k; MULT after k+1..k+B_W; product/scaled update and done=1 after edge k+B_W+1 (default: 9 cycles).
- flag during LOAD or MULT: ignored; operands do not change; the in-flight operation completes with the captured values.
- Operand inputs change outside the accepting edge: no effect.
- product/scaled change only on the MULT→DONE edge. They hold their value through IDLE, DONE and the next LOAD/MULT until the next completion.
- Width: accumulator A_W+B_W bits, unsigned. No overflow is possible: max (2^A_W−1)(2^B_W−1) fits.
- Zero operand: runs full B_W iterations; product=0.
- Reset mid-operation: immediate return to reset values. Prior result is lost.

Optional Feature:
- Macro SEQ_MUL_ROUND_EN.
- Defined: scaled = (product + 2^(B_W−1)) >> B_W, i.e. round-half-up. Addition performed at A_W+B_W+1 bits; result saturates to 2^A_W−1 if it exceeds A_W bits. This cannot occur for the default widths but is still implemented.
- Undefined: scaled = product[A_W+B_W-1:B_W], truncation.
- product is identical in both builds.

Test Plan:
- Reset then idle 5 cycles → product=0, scaled=0, busy=0, done=0.
- A=200, B=0x80, flag one cycle → busy for 9 cycles, then done=1; product=0x006400, scaled=0x0064. done stays high and values hold with flag=0.
- A=0xFFFF, B=0xFF → product=0xFEFF01, scaled=0xFEFF in both builds.
- A=3, B=0x80 → product=0x000180. scaled=0x0001 without SEQ_MUL_ROUND_EN; scaled=0x0002 with it.
- Start A=10, B=10; toggle flag and change operands during MULT. → result 0x000064 at the expected cycle. Then flag in DONE with A=0, B=0x55 → product=0 after 9 more cycles.
- Start A=1000, B=5; assert n_rst=0 at the 4th MULT cycle → all outputs 0 asynchronously. After release, state IDLE and no done pulse until a new flag.
